// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes x - y one bit per clock, LSB first,
// through a single full-subtractor cell and a registered borrow.
// Reports the difference, the unsigned borrow-out and the signed overflow.
//
// state | meaning
// IDLE  | waiting for start; x/y captured on the accepting edge
// SHIFT | one bit per cycle through the subtractor cell, WIDTH cycles
// DONE  | results valid, done pulses for one cycle, back to IDLE
module serial_subtractor #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  // Only the upper WIDTH-1 result bits are kept; the newest bit d is
  // prepended on the fly, so no register bit is shifted out unused.
  logic [WIDTH-2:0] r_q;
  logic             bq_q;
  logic [CW-1:0]    cnt_q;
  logic             sx_q, sy_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q, overflow_q;

  logic             a_bit, b_bit, d_bit, bout;
  logic [WIDTH-1:0] r_ext;
  logic             last_bit;

  // Full-subtractor cell on the current LSBs plus the registered borrow.
  always_comb begin
    a_bit    = a_q[0];
    b_bit    = b_q[0];
    d_bit    = a_bit ^ b_bit ^ bq_q;
    bout     = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bq_q);
    r_ext    = {d_bit, r_q};
    last_bit = (cnt_q == LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Operand/result shifting, borrow chain and result capture on the last bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      bq_q       <= 1'b0;
      cnt_q      <= '0;
      sx_q       <= 1'b0;
      sy_q       <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= x;
            b_q   <= y;
            bq_q  <= 1'b0;
            cnt_q <= '0;
            sx_q  <= x[WIDTH-1];
            sy_q  <= y[WIDTH-1];
          end
        end
        SHIFT: begin
          a_q   <= {1'b0, a_q[WIDTH-1:1]};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
          r_q   <= r_ext[WIDTH-1:1];
          bq_q  <= bout;
          cnt_q <= cnt_q + CW'(1);
          if (last_bit) begin
            diff_q     <= r_ext;
            borrow_q   <= bout;
            overflow_q <= (sx_q != sy_q) && (d_bit != sx_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH = 6).
module tb_serial_subtractor;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         busy, done, borrow, overflow;
  logic [W-1:0] diff;

  int n_vec = 0;
  int n_err = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .x        (x),
    .y        (y),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and observe 20 cycles after the accepting edge.
  // latency is the index (cycles after E0) where done was first seen, -1 if never.
  task automatic do_op(input logic [W-1:0] xv, input logic [W-1:0] yv,
                       output int busy_cyc, output int done_cyc, output int latency);
    x = xv; y = yv; start = 1'b1;
    tick();
    start = 1'b0;
    busy_cyc = 0; done_cyc = 0; latency = -1;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc++;
        if (latency < 0) latency = i;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    tick(); tick();
    reset = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (diff !== '0) begin n_err++; $display("FAIL reset_diff got %b want 000000", diff); end
    n_vec++; if (borrow !== 1'b0) begin n_err++; $display("FAIL reset_borrow got %b want 0", borrow); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
  endtask

  task automatic test_vectors();
    logic [W-1:0] tx [6] = '{6'b000001, 6'b000001, 6'b000000, 6'b100000, 6'b011111, 6'b100000};
    logic [W-1:0] ty [6] = '{6'b000000, 6'b000001, 6'b000001, 6'b000001, 6'b100000, 6'b100000};
    logic [W-1:0] ed [6] = '{6'b000001, 6'b000000, 6'b111111, 6'b011111, 6'b111111, 6'b000000};
    logic         eb [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic         eo [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int bc, dc, lat;
    for (int k = 0; k < 6; k++) begin
      do_op(tx[k], ty[k], bc, dc, lat);
      n_vec++; if (diff !== ed[k]) begin n_err++; $display("FAIL vec%0d_diff got %b want %b", k, diff, ed[k]); end
      n_vec++; if (borrow !== eb[k]) begin n_err++; $display("FAIL vec%0d_borrow got %b want %b", k, borrow, eb[k]); end
      n_vec++; if (overflow !== eo[k]) begin n_err++; $display("FAIL vec%0d_overflow got %b want %b", k, overflow, eo[k]); end
      n_vec++; if (bc !== W) begin n_err++; $display("FAIL vec%0d_busy_cycles got %0d want %0d", k, bc, W); end
      n_vec++; if (dc !== 1) begin n_err++; $display("FAIL vec%0d_done_pulses got %0d want 1", k, dc); end
      n_vec++; if (lat !== W) begin n_err++; $display("FAIL vec%0d_done_latency got %0d want %0d", k, lat, W); end
    end
  endtask

  task automatic test_ignored_start();
    int dc, lat;
    x = 6'b000101; y = 6'b000011; start = 1'b1;
    tick();
    start = 1'b0;
    dc = 0; lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin start = 1'b1; x = 6'b111111; y = 6'b000000; end
      if (i == 3) start = 1'b0;
      if (done) begin
        dc++;
        if (lat < 0) lat = i;
      end
      tick();
    end
    n_vec++; if (dc !== 1) begin n_err++; $display("FAIL ignored_start_done_pulses got %0d want 1", dc); end
    n_vec++; if (lat !== W) begin n_err++; $display("FAIL ignored_start_latency got %0d want %0d", lat, W); end
    n_vec++; if (diff !== 6'b000010) begin n_err++; $display("FAIL ignored_start_diff got %b want 000010", diff); end
    n_vec++; if (borrow !== 1'b0) begin n_err++; $display("FAIL ignored_start_borrow got %b want 0", borrow); end
    x = 6'b101010; y = 6'b010101;
    for (int i = 0; i < 5; i++) tick();
    n_vec++; if (diff !== 6'b000010) begin n_err++; $display("FAIL hold_diff got %b want 000010", diff); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL hold_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_shift();
    int dc, bc, lat;
    x = 6'b001001; y = 6'b000010; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before_reset got %b want 1", busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_reset_done got %b want 0", done); end
    n_vec++; if (diff !== '0) begin n_err++; $display("FAIL mid_reset_diff got %b want 000000", diff); end
    dc = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) dc++;
      tick();
    end
    n_vec++; if (dc !== 0) begin n_err++; $display("FAIL mid_reset_activity got %0d want 0", dc); end
    do_op(6'b000111, 6'b000010, bc, dc, lat);
    n_vec++; if (diff !== 6'b000101) begin n_err++; $display("FAIL after_reset_diff got %b want 000101", diff); end
    n_vec++; if (lat !== W) begin n_err++; $display("FAIL after_reset_latency got %0d want %0d", lat, W); end
    n_vec++; if (bc !== W) begin n_err++; $display("FAIL after_reset_busy_cycles got %0d want %0d", bc, W); end
  endtask

  task automatic test_reset_with_start();
    int act;
    reset = 1'b1; start = 1'b1; x = 6'b000011; y = 6'b000001;
    tick();
    reset = 1'b0; start = 1'b0;
    act = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy || done) act++;
      tick();
    end
    n_vec++; if (act !== 0) begin n_err++; $display("FAIL reset_with_start_activity got %0d want 0", act); end
    n_vec++; if (diff !== '0) begin n_err++; $display("FAIL reset_with_start_diff got %b want 000000", diff); end
  endtask

  task automatic test_back_to_back();
    int dc, first, second;
    x = 6'b001010; y = 6'b000011; start = 1'b1;
    tick();
    dc = 0; first = -1; second = -1;
    for (int i = 0; i < 24; i++) begin
      if (done) begin
        dc++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      tick();
    end
    start = 1'b0;
    n_vec++; if (dc !== 3) begin n_err++; $display("FAIL b2b_done_pulses got %0d want 3", dc); end
    n_vec++; if (first !== W) begin n_err++; $display("FAIL b2b_first_done got %0d want %0d", first, W); end
    n_vec++; if (second - first !== W + 2) begin n_err++; $display("FAIL b2b_spacing got %0d want %0d", second - first, W + 2); end
    n_vec++; if (diff !== 6'b000111) begin n_err++; $display("FAIL b2b_diff got %b want 000111", diff); end
    for (int i = 0; i < 10; i++) tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_vectors();
    test_ignored_start();
    test_reset_mid_shift();
    test_reset_with_start();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Sequential, bit-serial counterpart to the combinational 6-bit ripple adder. It computes x − y one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It uses a start/busy/done handshake and sits in the datapath where area matters more than latency. Alongside the difference it reports an unsigned borrow and a two's-complement overflow flag.

## Interface
- WIDTH, 6, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- x  input  WIDTH  minuend; sampled on the edge that accepts start
- y  input  WIDTH  subtrahend; sampled on the edge that accepts start
- busy  output  1  high while bits are being processed (SHIFT)
- done  output  1  one-cycle pulse; diff/borrow/overflow valid from this cycle
- diff  output  WIDTH  x − y modulo 2^WIDTH
- borrow  output  1  final borrow-out; 1 iff x < y unsigned
- overflow  output  1  signed overflow: (x[MSB] ≠ y[MSB]) && (diff[MSB] ≠ x[MSB])

## Operation
- One clock; reset is synchronous and active-high.
- Internal state: FSM, A/B operand shift registers, R result shift register, borrow flop bq, bit counter cnt (width ⌈log2 WIDTH⌉), latched x/y sign bits.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - busy = 0, done = 0.
  - If start = 1: A ← x, B ← y, bq ← 0, cnt ← 0, sign bits latched, next state SHIFT.
  - Otherwise stay in IDLE.
- SHIFT (per cycle), with a = A[0], b = B[0]:
  - d = a ^ b ^ bq
  - bout = (~a & b) | (~(a ^ b) & bq)
  - R ← {d, R[WIDTH−1:1]}; A, B shift right by 1; bq ← bout; cnt ← cnt + 1.
  - When cnt = WIDTH−1 (last bit), in addition:
    - diff ← {d, R[WIDTH−1:1]}
    - borrow ← bout
    - overflow computed from the latched sign bits and d
    - next state DONE.
- DONE: done = 1, busy = 0. Next state is IDLE unconditionally.
- Output hold: diff/borrow/overflow change only on the edge that enters DONE or on reset; they hold between operations.
- start is ignored in SHIFT and DONE. No queueing; a dropped start must be reissued in IDLE.
- x/y may change freely after the accepting edge; in-flight results are unaffected.
- Reset in any state, including mid-SHIFT:
  - Next state IDLE; in-flight operation discarded, no done pulse.
  - All outputs 0.
  - A, B, R, bq, cnt cleared.

## Timing
- Reset values: busy = 0, done = 0, diff = 0, borrow = 0, overflow = 0, state = IDLE.
- Call the edge that samples start = 1 in IDLE E0.
- busy is high in the WIDTH cycles after E0 through E(WIDTH−1) inclusive.
- Bits 0..WIDTH−1 are processed at edges E1..E(WIDTH).
- Outputs load at E(WIDTH); done is high for exactly the one cycle after E(WIDTH).
- Earliest next accept is edge E(WIDTH+2), from IDLE, so throughput is one operation per WIDTH+2 cycles.
- Worked example, WIDTH = 6:
  - start high before E0.
  - busy high after E0, low after E6.
  - done high between E6 and E7.
- start held high continuously starts a new operation every WIDTH+2 cycles.
- Reset asserted together with start: reset wins; stay in IDLE.

## Test plan
- Reset, then x = 000001, y = 000000, start for 1 cycle.
  - busy high 6 cycles; done pulses 1 cycle after E6.
  - diff = 000001, borrow = 0, overflow = 0.
- x = 000001, y = 000001 → diff = 000000, borrow = 0, overflow = 0.
- x = 000000, y = 000001 → diff = 111111, borrow = 1, overflow = 0.
- x = 100000, y = 000001 (−32 − 1) → diff = 011111, borrow = 0, overflow = 1.
- Start x = 000101, y = 000011; pulse start with x = 111111 during SHIFT.
  - Second start is ignored; diff = 000010; exactly one done pulse.
  - Outputs hold 000010 until the next operation.
- Assert reset at cycle 3 of SHIFT.
  - Next cycle: busy = 0, all outputs 0, no done pulse.
  - A fresh start afterwards completes normally with full latency.
